// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer.
//   Lookup is combinational from registered state. Updates become visible on
//   the cycle after the edge that takes them. There is no bypass.
//   Each way keeps, per set: a valid bit, a tag, a target and a 2-bit
//   saturating counter. Each set keeps a round-robin victim pointer.
// Ports:
//   clk, rst (async, active-low)
//   pc                    -> target_pc, valid, predictedTaken  (lookup)
//   update, update_pc, update_target, update_taken              (training)
//   flush                 synchronous invalidate-all; it beats update

// One way: storage for all sets, plus its read and match ports.
module btb_way #(
  parameter int XLEN  = 32,
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             rd_hit,
  output logic [XLEN-1:0]  rd_target,
  output logic [1:0]       rd_ctr,
  input  logic [IDX_W-1:0] up_idx,
  input  logic [TAG_W-1:0] up_tag,
  output logic             up_match,
  output logic             up_valid,
  output logic [1:0]       up_ctr,
  input  logic             wr_en,
  input  logic             wr_target_en,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [1:0]       wr_ctr
);
  logic [SETS-1:0]       vld;
  logic [SETS-1:0][1:0]  ctr;
  logic [TAG_W-1:0]      tag_mem [SETS];
  logic [XLEN-1:0]       tgt_mem [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      ctr <= '0;
    end else if (flush) begin
      vld <= '0;
      ctr <= '0;
    end else if (wr_en) begin
      vld[up_idx] <= 1'b1;
      ctr[up_idx] <= wr_ctr;
    end
  end

  // Tag and target storage is not reset. A stale value is always masked
  // by a cleared valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[up_idx] <= up_tag;
      if (wr_target_en) tgt_mem[up_idx] <= wr_target;
    end
  end

  assign rd_hit    = vld[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_target = tgt_mem[rd_idx];
  assign rd_ctr    = ctr[rd_idx];
  assign up_valid  = vld[up_idx];
  assign up_match  = vld[up_idx] && (tag_mem[up_idx] == up_tag);
  assign up_ctr    = ctr[up_idx];
endmodule

module btb_assoc #(
  parameter int XLEN = 32,
  parameter int SETS = 16,
  parameter int WAYS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            update,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  input  logic            flush,
  output logic [XLEN-1:0] target_pc,
  output logic            valid,
  output logic            predictedTaken
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [IDX_W-1:0] rd_idx, up_idx;
  logic [TAG_W-1:0] rd_tag, up_tag;
  assign rd_idx = pc[IDX_W+1:2];
  assign rd_tag = pc[XLEN-1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[XLEN-1:IDX_W+2];

  // The low address bits never matter.
  logic unused;
  assign unused = ^{pc[1:0], update_pc[1:0]};

  logic [WAYS-1:0]            rd_hit, up_match, up_valid, wr_en;
  logic [WAYS-1:0][XLEN-1:0]  rd_target;
  logic [WAYS-1:0][1:0]       rd_ctr, up_ctr;

  logic             up_hit, has_inv, do_wr, alloc;
  logic [PTR_W-1:0] hit_way, inv_way, ptr_cur, wr_way;
  logic [1:0]       hit_ctr, new_ctr;

  // Lookup. The loop scans downward, so the lowest matching way is
  // assigned last and wins.
  always_comb begin
    valid          = 1'b0;
    target_pc      = '0;
    predictedTaken = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (rd_hit[w]) begin
        valid          = 1'b1;
        target_pc      = rd_target[w];
        predictedTaken = rd_ctr[w][1];
      end
    end
  end

  // Update path. Hit detection uses the same lowest-way rule as lookup.
  always_comb begin
    up_hit  = 1'b0;
    hit_way = '0;
    hit_ctr = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (up_match[w]) begin
        up_hit  = 1'b1;
        hit_way = PTR_W'(w);
        hit_ctr = up_ctr[w];
      end
      if (!up_valid[w]) begin
        has_inv = 1'b1;
        inv_way = PTR_W'(w);
      end
    end
    wr_way = up_hit ? hit_way : (has_inv ? inv_way : ptr_cur);
    do_wr  = update && !flush && (up_hit || update_taken);
    alloc  = update && !flush && !up_hit && update_taken;
    if (!up_hit)
      new_ctr = 2'b10;
    else if (update_taken)
      new_ctr = (hit_ctr == 2'b11) ? 2'b11 : hit_ctr + 2'b01;
    else
      new_ctr = (hit_ctr == 2'b00) ? 2'b00 : hit_ctr - 2'b01;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign wr_en[w] = do_wr && (wr_way == PTR_W'(w));
    btb_way #(.XLEN(XLEN), .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .rd_idx       (rd_idx),
      .rd_tag       (rd_tag),
      .rd_hit       (rd_hit[w]),
      .rd_target    (rd_target[w]),
      .rd_ctr       (rd_ctr[w]),
      .up_idx       (up_idx),
      .up_tag       (up_tag),
      .up_match     (up_match[w]),
      .up_valid     (up_valid[w]),
      .up_ctr       (up_ctr[w]),
      .wr_en        (wr_en[w]),
      .wr_target_en (update_taken),
      .wr_target    (update_target),
      .wr_ctr       (new_ctr)
    );
  end

  // The round-robin pointer advances on every allocation, whether or not
  // the victim came from it. A direct-mapped BTB needs no pointer state.
  if (WAYS > 1) begin : g_ptr
    logic [SETS-1:0][PTR_W-1:0] ptr;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       ptr <= '0;
      else if (flush) ptr <= '0;
      else if (alloc) ptr[up_idx] <= ptr[up_idx] + PTR_W'(1);
    end
    assign ptr_cur = ptr[up_idx];
  end else begin : g_noptr
    assign ptr_cur = '0;
  end
endmodule

// File: tb/tb_btb_assoc.sv
module tb_btb_assoc;
  localparam int XLEN = 32, SETS = 16, WAYS = 2;
  localparam int SH = 2 + $clog2(SETS);

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc, update_pc, update_target, target_pc;
  logic            update, update_taken, flush, valid, predictedTaken;

  btb_assoc #(.XLEN(XLEN), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .pc(pc), .update(update), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken), .flush(flush),
    .target_pc(target_pc), .valid(valid), .predictedTaken(predictedTaken)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk3(input string nm, input logic ev, input logic [31:0] et, input logic ep);
    chk({nm, " valid"}, {31'd0, valid}, {31'd0, ev});
    chk({nm, " target"}, target_pc, et);
    chk({nm, " taken"}, {31'd0, predictedTaken}, {31'd0, ep});
  endtask

  task automatic drive(input logic u, input logic [31:0] upc, input logic [31:0] ut,
                       input logic tk, input logic fl, input logic [31:0] look);
    update = u; update_pc = upc; update_target = ut; update_taken = tk;
    flush = fl; pc = look;
  endtask

  // Vector table. Outputs are checked in the same cycle as the inputs,
  // so the expected values describe the state before this cycle's update.
  typedef struct {
    logic upd; logic [31:0] upc; logic [31:0] utgt; logic utk; logic fl;
    logic [31:0] look; logic ev; logic [31:0] et; logic ep;
  } vec_t;
  vec_t tv[$];

  task automatic av(input logic u, input logic [31:0] upc, input logic [31:0] ut,
                    input logic tk, input logic fl, input logic [31:0] look,
                    input logic ev, input logic [31:0] et, input logic ep);
    vec_t v;
    v.upd = u; v.upc = upc; v.utgt = ut; v.utk = tk; v.fl = fl;
    v.look = look; v.ev = ev; v.et = et; v.ep = ep;
    tv.push_back(v);
  endtask

  // Reference model: plain arrays driven by the replacement rules.
  bit          m_v   [SETS][WAYS];
  int unsigned m_tag [SETS][WAYS];
  logic [31:0] m_tgt [SETS][WAYS];
  int          m_ctr [SETS][WAYS];
  int          m_ptr [SETS];

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_v[s][w] = 0;
        m_ctr[s][w] = 0;
      end
    end
  endfunction

  function automatic int m_find(input logic [31:0] a);
    int s = int'((a >> 2) % SETS);
    for (int w = 0; w < WAYS; w++)
      if (m_v[s][w] && m_tag[s][w] == (a >> SH)) return w;
    return -1;
  endfunction

  function automatic void m_update(input logic [31:0] a, input logic [31:0] t, input bit tk);
    int s = int'((a >> 2) % SETS);
    int w = m_find(a);
    if (w >= 0) begin
      if (tk) begin
        m_ctr[s][w] = (m_ctr[s][w] < 3) ? m_ctr[s][w] + 1 : 3;
        m_tgt[s][w] = t;
      end else begin
        m_ctr[s][w] = (m_ctr[s][w] > 0) ? m_ctr[s][w] - 1 : 0;
      end
    end else if (tk) begin
      w = m_ptr[s];
      for (int i = WAYS-1; i >= 0; i--) if (!m_v[s][i]) w = i;
      m_v[s][w] = 1; m_tag[s][w] = a >> SH; m_tgt[s][w] = t; m_ctr[s][w] = 2;
      m_ptr[s] = (m_ptr[s] + 1) % WAYS;
    end
  endfunction

  localparam logic [31:0] A = 32'h000A0000, B = 32'h000B0000, C = 32'h000C0000;
  localparam logic [31:0] D = 32'h000D0000, E = 32'h00000104, N = 32'h00001000;

  initial begin
    drive(0, 0, 0, 0, 0, A);
    rst = 1'b0;
    #3 chk3("in_reset", 1'b0, 32'h0, 1'b0);
    #9 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); chk3("after_reset", 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;

    //  upd upc  utgt          tk fl look      ev  et            ep
    av(1, A, 32'h000A0020, 1, 0, A,           0, 32'h0,        0);
    av(0, 0, 0,            0, 0, A,           1, 32'h000A0020, 1);
    av(1, B, 32'h000B0020, 1, 0, B,           0, 32'h0,        0);
    av(0, 0, 0,            0, 0, B,           1, 32'h000B0020, 1);
    av(0, 0, 0,            0, 0, A,           1, 32'h000A0020, 1);
    av(1, C, 32'h000C0020, 1, 0, C,           0, 32'h0,        0);
    av(0, 0, 0,            0, 0, A,           0, 32'h0,        0);
    av(0, 0, 0,            0, 0, B,           1, 32'h000B0020, 1);
    av(0, 0, 0,            0, 0, C,           1, 32'h000C0020, 1);
    av(1, B, 32'hDEAD0000, 0, 0, B,           1, 32'h000B0020, 1);
    av(1, B, 32'hDEAD0000, 0, 0, B,           1, 32'h000B0020, 0);
    av(0, 0, 0,            0, 0, B,           1, 32'h000B0020, 0);
    av(1, B, 32'h000B0020, 1, 0, B,           1, 32'h000B0020, 0);
    av(1, B, 32'h000B0020, 1, 0, B,           1, 32'h000B0020, 0);
    av(1, B, 32'h000B0020, 1, 0, B,           1, 32'h000B0020, 1);
    av(1, B, 32'h000B0020, 1, 0, B,           1, 32'h000B0020, 1);
    av(0, 0, 0,            0, 0, B,           1, 32'h000B0020, 1);
    av(1, B, 0,            0, 0, B,           1, 32'h000B0020, 1);
    av(1, B, 0,            0, 0, B,           1, 32'h000B0020, 1);
    av(0, 0, 0,            0, 0, B,           1, 32'h000B0020, 0);
    av(1, C, 32'h0000C100, 1, 0, C,           1, 32'h000C0020, 1);
    av(0, 0, 0,            0, 0, C,           1, 32'h0000C100, 1);
    av(1, N, 32'h00002000, 0, 0, N,           0, 32'h0,        0);
    av(0, 0, 0,            0, 0, N,           0, 32'h0,        0);
    av(1, D, 32'h000D0020, 1, 0, D,           0, 32'h0,        0);
    av(0, 0, 0,            0, 0, B,           0, 32'h0,        0);
    av(0, 0, 0,            0, 0, C | 32'h2,   1, 32'h0000C100, 1);
    av(1, E, 32'h00000200, 1, 1, D,           1, 32'h000D0020, 1);
    av(0, 0, 0,            0, 0, D,           0, 32'h0,        0);
    av(0, 0, 0,            0, 0, E,           0, 32'h0,        0);
    av(0, 0, 0,            0, 0, C,           0, 32'h0,        0);

    foreach (tv[i]) begin
      drive(tv[i].upd, tv[i].upc, tv[i].utgt, tv[i].utk, tv[i].fl, tv[i].look);
      @(negedge clk);
      chk3($sformatf("vec%0d", i), tv[i].ev, tv[i].et, tv[i].ep);
      @(posedge clk); #1;
    end

    // Asynchronous reset between edges clears the entry immediately.
    drive(1, A, 32'h000A0020, 1, 0, A);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, A);
    @(negedge clk); chk3("pre_rst_pulse", 1'b1, 32'h000A0020, 1'b1);
    #1 rst = 1'b0;
    #1 chk3("rst_low", 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #1 chk3("rst_released", 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;

    // Reset held across an update edge wins, and the update leaves no trace.
    drive(1, B, 32'h000B0020, 1, 0, B);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    drive(0, 0, 0, 0, 0, B);
    @(negedge clk); chk3("rst_mid_update", 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;

    // Randomized traffic against the model. DUT state is clean here.
    m_clear();
    for (int n = 0; n < 800; n++) begin
      logic [31:0] ua, la, ut;
      bit u, tk, fl, ev, ep;
      logic [31:0] et;
      int w, s;
      ua = ($urandom_range(0, 5) << SH) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      la = ($urandom_range(0, 5) << SH) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      ut = $urandom;
      u  = ($urandom_range(0, 9) < 6);
      tk = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 49) == 0);
      drive(u, ua, ut, tk, fl, la);
      @(negedge clk);
      w = m_find(la);
      s = int'((la >> 2) % SETS);
      ev = (w >= 0);
      et = ev ? m_tgt[s][w] : 32'h0;
      ep = ev && (m_ctr[s][w] >= 2);
      chk3($sformatf("rand%0d", n), ev, et, ep);
      if (fl) m_clear();
      else if (u) m_update(ua, ut, tk);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
